// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: elastic valid/ready stage with a main entry plus one skid
// entry, synchronous flush, and load-use hazard detection against both held entries.
module id_ex_pipe_reg #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int CTRL_W      = 10,
  parameter int MEMREAD_BIT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              hazard_stall
);

  typedef struct packed {
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t id_entry;
  logic   accept;
  logic   pop;
  logic   main_hit;
  logic   skid_hit;

  // A held load whose destination (rt) is a source of the decoding instruction.
  function automatic logic load_use(input entry_t e,
                                    input logic [REG_AW-1:0] rs,
                                    input logic [REG_AW-1:0] rt);
    return e.ctrl[MEMREAD_BIT] && (e.rt != '0) && ((e.rt == rs) || (e.rt == rt));
  endfunction

  // NOTE: sequential state uses non-blocking assignments only; all next-state
  // values come from the always_comb below so the flops see a consistent snapshot.
  // The two entries are plain flops (not a RAM), so resetting them is cheap and
  // guarantees ex_* read back as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // NOTE: every variable is given a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = id_entry;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_d = id_entry;
          end else if (accept) begin
            state_d = TWO;
            skid_d  = id_entry;
          end else if (pop) begin
            state_d = EMPTY;
            main_d  = '0;
          end
        end
        TWO: begin
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  // id_ready is built from registered state and id_*/flush only, never from ex_ready.
  always_comb begin
    id_entry     = '{rd1: id_rd1, rd2: id_rd2, imm: id_imm, pc: id_pc,
                     rs: id_rs, rt: id_rt, rd: id_rd, ctrl: id_ctrl};
    main_hit     = (state_q != EMPTY) && load_use(main_q, id_rs, id_rt);
    skid_hit     = (state_q == TWO)   && load_use(skid_q, id_rs, id_rt);
    hazard_stall = id_valid && (main_hit || skid_hit);
    id_ready     = (state_q != TWO) && !hazard_stall && !flush;
    ex_valid     = (state_q != EMPTY);
    accept       = id_valid && id_ready;
    pop          = ex_valid && ex_ready;
    ex_rd1       = main_q.rd1;
    ex_rd2       = main_q.rd2;
    ex_imm       = main_q.imm;
    ex_pc        = main_q.pc;
    ex_rs        = main_q.rs;
    ex_rt        = main_q.rt;
    ex_rd        = main_q.rd;
    ex_ctrl      = main_q.ctrl;
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: a queue scoreboard of in-flight instructions
// predicts handshake, hazard and output values every cycle.
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [9:0]  ctrl;
  } instr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_rd1, id_rd2, id_imm, id_pc;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [9:0]  id_ctrl;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_rd1, ex_rd2, ex_imm, ex_pc;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [9:0]  ex_ctrl;
  logic        hazard_stall;

  instr_t cur;
  instr_t sb_q[$];
  int     vectors    = 0;
  int     miscompares = 0;

  id_ex_pipe_reg #(
    .DATA_W(32), .REG_AW(5), .CTRL_W(10), .MEMREAD_BIT(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_pc(id_pc),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_ctrl(id_ctrl),
    .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic instr_t mk(input logic [31:0] pc, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [9:0] ctrl);
    instr_t i;
    i.rd1  = pc ^ 32'hA5A5_0000;
    i.rd2  = ~pc;
    i.imm  = {pc[15:0], pc[15:0]};
    i.pc   = pc;
    i.rs   = rs;
    i.rt   = rt;
    i.rd   = pc[6:2];
    i.ctrl = ctrl;
    return i;
  endfunction

  task automatic drive(input logic v, input instr_t i);
    cur      = i;
    id_valid = v;
    id_rd1   = i.rd1;
    id_rd2   = i.rd2;
    id_imm   = i.imm;
    id_pc    = i.pc;
    id_rs    = i.rs;
    id_rt    = i.rt;
    id_rd    = i.rd;
    id_ctrl  = i.ctrl;
  endtask

  function automatic instr_t observed();
    return '{rd1: ex_rd1, rd2: ex_rd2, imm: ex_imm, pc: ex_pc,
             rs: ex_rs, rt: ex_rt, rd: ex_rd, ctrl: ex_ctrl};
  endfunction

  // One clock: check at the falling edge, advance the scoreboard, return #1 after rise.
  task automatic cycle();
    logic exp_valid, exp_haz, exp_ready;
    @(negedge clk);
    exp_valid = rst_n && (sb_q.size() != 0);
    exp_haz   = 1'b0;
    if (rst_n && id_valid)
      foreach (sb_q[k])
        if (sb_q[k].ctrl[2] && sb_q[k].rt != 5'd0 &&
            (sb_q[k].rt == id_rs || sb_q[k].rt == id_rt))
          exp_haz = 1'b1;
    exp_ready = (sb_q.size() < 2) && !exp_haz && !flush;
    check("ex_valid", ex_valid, exp_valid);
    check("hazard_stall", hazard_stall, exp_haz);
    if (rst_n) check("id_ready", id_ready, exp_ready);
    if (exp_valid) check("ex_entry", observed(), sb_q[0]);
    else           check("ex_bubble_zero", observed(), '0);
    if (!rst_n || flush) begin
      sb_q.delete();
    end else begin
      if (exp_valid && ex_ready) void'(sb_q.pop_front());
      if (id_valid && exp_ready) sb_q.push_back(cur);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    flush    = 1'b0;
    ex_ready = 1'b0;
    drive(1'b0, '0);
    #3;
    check("rst_ex_valid", ex_valid, 1'b0);
    check("rst_ex_ctrl", ex_ctrl, 10'd0);
    check("rst_hazard", hazard_stall, 1'b0);
    cycle();
    cycle();
    #2 rst_n = 1'b1;

    // Streaming at full throughput.
    ex_ready = 1'b1;
    drive(1'b1, mk(32'h4, 5'd1, 5'd2, 10'h001)); cycle();
    drive(1'b1, mk(32'h8, 5'd1, 5'd2, 10'h001)); cycle();
    drive(1'b1, mk(32'hC, 5'd1, 5'd2, 10'h001)); cycle();
    drive(1'b1, mk(32'h10, 5'd1, 5'd2, 10'h001)); cycle();
    drive(1'b0, '0);
    repeat (3) cycle();

    // Backpressure: fill main and skid, third offer held off.
    ex_ready = 1'b0;
    drive(1'b1, mk(32'h4, 5'd3, 5'd4, 10'h010)); cycle();
    drive(1'b1, mk(32'h8, 5'd3, 5'd4, 10'h020)); cycle();
    drive(1'b1, mk(32'hC, 5'd3, 5'd4, 10'h040)); cycle();
    cycle();
    ex_ready = 1'b1;
    cycle();
    cycle();
    drive(1'b0, '0);
    repeat (3) cycle();

    // Load-use hazard against the main entry, then the rt=0 case.
    ex_ready = 1'b0;
    drive(1'b1, mk(32'h20, 5'd0, 5'd5, 10'h004)); cycle();
    drive(1'b1, mk(32'h24, 5'd5, 5'd3, 10'h000)); cycle();
    cycle();
    ex_ready = 1'b1;
    cycle();
    cycle();
    drive(1'b0, '0);
    repeat (2) cycle();
    ex_ready = 1'b0;
    drive(1'b1, mk(32'h30, 5'd0, 5'd0, 10'h004)); cycle();
    drive(1'b1, mk(32'h34, 5'd0, 5'd3, 10'h000)); cycle();
    ex_ready = 1'b1;
    drive(1'b0, '0);
    repeat (3) cycle();

    // Load-use hazard against the skid entry.
    ex_ready = 1'b0;
    drive(1'b1, mk(32'h40, 5'd1, 5'd2, 10'h000)); cycle();
    drive(1'b1, mk(32'h44, 5'd0, 5'd7, 10'h004)); cycle();
    drive(1'b1, mk(32'h48, 5'd6, 5'd7, 10'h000)); cycle();
    cycle();
    ex_ready = 1'b1;
    repeat (4) cycle();
    drive(1'b0, '0);
    repeat (2) cycle();

    // Flush from TWO with a valid offer, then flush together with a pop.
    ex_ready = 1'b0;
    drive(1'b1, mk(32'h50, 5'd1, 5'd2, 10'h155)); cycle();
    drive(1'b1, mk(32'h54, 5'd1, 5'd2, 10'h0AA)); cycle();
    drive(1'b1, mk(32'h58, 5'd1, 5'd2, 10'h3FF));
    flush = 1'b1; cycle();
    flush = 1'b0;
    drive(1'b1, mk(32'h5C, 5'd1, 5'd2, 10'h001)); cycle();
    drive(1'b0, '0); cycle();
    ex_ready = 1'b1;
    cycle();
    drive(1'b1, mk(32'h60, 5'd1, 5'd2, 10'h002)); cycle();
    drive(1'b0, '0);
    flush = 1'b1; cycle();
    flush = 1'b0; cycle();

    // Asynchronous reset while holding one entry.
    ex_ready = 1'b0;
    drive(1'b1, mk(32'h70, 5'd1, 5'd2, 10'h2A5)); cycle();
    drive(1'b0, '0);
    check("pre_rst_ex_valid", ex_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_ex_valid", ex_valid, 1'b0);
    check("async_ex_ctrl", ex_ctrl, 10'd0);
    check("async_entry_zero", observed(), '0);
    sb_q.delete();
    cycle();
    #2 rst_n = 1'b1;
    ex_ready = 1'b1;
    drive(1'b1, mk(32'h74, 5'd1, 5'd2, 10'h008)); cycle();
    drive(1'b0, '0);
    repeat (2) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

Parametrised ID/EX pipeline register with an elastic valid/ready handshake, a 2-entry skid buffer, synchronous flush and built-in load-use hazard detection. It sits between the decode stage and the execute stage. It carries operand data, PC+4, register specifiers and a packed control vector. It stalls decode when a load in EX would feed the instruction being decoded, and it zeroes control on every bubble.

## Interface
Parameters:
- DATA_W, 32, width of operand, immediate and PC fields
- REG_AW, 5, register specifier width
- CTRL_W, 10, packed control vector width
- MEMREAD_BIT, 2, index of MemRead inside the control vector

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  decode holds a valid instruction
- id_ready  out  1  stage accepts this cycle
- id_rd1, id_rd2, id_imm, id_pc  in  DATA_W  read data 1/2, sign-extended immediate, PC+4
- id_rs, id_rt, id_rd  in  REG_AW  register specifiers
- id_ctrl  in  CTRL_W  control vector
- flush  in  1  synchronous kill of all held entries
- ex_valid  out  1  EX output entry valid
- ex_ready  in  1  execute consumes the entry
- ex_rd1, ex_rd2, ex_imm, ex_pc  out  DATA_W  registered copies
- ex_rs, ex_rt, ex_rd  out  REG_AW  registered copies
- ex_ctrl  out  CTRL_W  registered control; 0 whenever ex_valid=0
- hazard_stall  out  1  load-use hazard detected this cycle

## Operation
- Storage: main entry, which drives the ex_* outputs, plus one skid entry. State is EMPTY, ONE or TWO.
- accept = id_valid & id_ready.
- pop = ex_valid & ex_ready.
- id_ready = (state != TWO) & !hazard_stall & !flush.
- Load-use hazard: for each held entry E (main, skid), test E.valid & E.ctrl[MEMREAD_BIT] & (E.rt != 0) & (E.rt == id_rs | E.rt == id_rt). hazard_stall = id_valid & (OR of that test over both entries). It is combinational.
- Transitions, with flush having priority:
  - flush=1: go to EMPTY. Clear both entries and drive all ex_* outputs to 0.
  - EMPTY: accept -> ONE, id_* loaded into main.
  - ONE, accept & pop: stay ONE, main replaced by id_*.
  - ONE, accept & !pop: -> TWO, id_* loaded into skid.
  - ONE, !accept & pop: -> EMPTY, main cleared to 0.
  - ONE, neither: hold.
  - TWO, pop: -> ONE, skid moves to main, skid cleared.
  - TWO, !pop: hold.
- ex_valid = (state != EMPTY).
- Held data never changes while ex_valid=1 & ex_ready=0.
- No arithmetic is performed; all fields pass through bit-exact.

## Timing
- Reset, asynchronous on rst_n low:
  - state EMPTY, skid cleared.
  - ex_valid=0; every ex_* data, specifier and control output is 0.
  - hazard_stall=0; id_ready=1 when rst_n is high and flush=0.
- Latency: 1 cycle from accept to ex_valid when the stage is empty or popping.
- Throughput: 1 instruction/cycle with ex_ready held high.
- id_ready depends only on registered state plus id_* and flush. There is no combinational path from ex_ready to id_ready.
- Backpressure: at most 2 instructions are absorbed after ex_ready drops. id_ready falls the cycle after the skid fills.
- Hazard bubble: while hazard_stall=1 the main entry drains normally and no new entry is loaded. EX therefore sees ex_valid=0 with ex_ctrl=0 (a NOP) for the cycle after the load leaves.
- Flush together with accept: the input is discarded. Flush together with pop: the pop completes, state goes to EMPTY.
- Reset asserted mid-transfer: all entries are lost immediately. No handshake is completed that cycle.

## Test plan
- Reset, then stream 4 instructions with ex_ready=1, id_pc=0x4,0x8,0xC,0x10 -> ex_pc shows the same sequence, one cycle after each accept; ex_valid stays high for 4 cycles; id_ready stays 1.
- Accept 0x4 and 0x8 with ex_ready=0, then offer 0xC -> id_ready=0 with state TWO and 0xC held off. Raise ex_ready -> outputs 0x4, 0x8, 0xC in order with none lost or duplicated.
- Load in main (ctrl[2]=1, rt=5), decode offers rs=5 -> hazard_stall=1, id_ready=0. After the pop, ex_valid=0 and ex_ctrl=0 for 1 cycle, then the dependent instruction is accepted. Repeat with rt=0 -> no stall.
- State TWO, assert flush for 1 cycle with id_valid=1 -> the next cycle has ex_valid=0, all ex_* =0, the input is not captured, and id_ready=1.
- Drive rst_n low asynchronously between clock edges while state is ONE -> ex_valid and ex_ctrl go to 0 immediately without a clock edge; the first accept after rst_n rises appears one cycle later.
